// File: rtl/timer_ctrl_if.sv
// Button-pulse inputs and display/status outputs of the countdown timer.
// The DUT attaches through the slave modport; the driver of the buttons uses master.
interface timer_ctrl_if;
    logic       min_rise;
    logic       sec_rise;
    logic       start_rise;
    logic       clear_rise;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic       running;
    logic       alarm;
    logic       sec_tick;

    modport slave (
        input  min_rise, sec_rise, start_rise, clear_rise,
        output minutes, seconds, running, alarm, sec_tick
    );

    modport master (
        output min_rise, sec_rise, start_rise, clear_rise,
        input  minutes, seconds, running, alarm, sec_tick
    );
endinterface

// File: rtl/timer_ctrl.sv
// Minutes/seconds countdown timer: SET / RUN / PAUSE / ALARM with registered outputs.
// Define TIMER_CTRL_ALARM_TIMEOUT_EN to make ALARM clear itself after ALARM_SECS seconds.
module timer_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 100000000,
    parameter int unsigned ALARM_SECS    = 30
) (
    input  logic         clk,
    input  logic         rst,
    timer_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_SET   = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_ALARM = 2'd3;

    localparam int unsigned   PW      = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

    if (TICKS_PER_SEC < 2 || ALARM_SECS < 1) begin : g_param_check
        $error("timer_ctrl: TICKS_PER_SEC must be >= 2 and ALARM_SECS >= 1");
    end

    logic [1:0]    state_q, state_d;
    logic [6:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;
    logic          running_q, running_d;
    logic          alarm_q, alarm_d;
    logic          pre_wrap_s;
    logic          time_zero_s;
    logic          last_sec_s;
`ifdef TIMER_CTRL_ALARM_TIMEOUT_EN
    localparam int unsigned    ACW      = $clog2(ALARM_SECS + 1);
    localparam logic [ACW-1:0] ACNT_MAX = ACW'(ALARM_SECS - 1);
    logic [ACW-1:0] acnt_q, acnt_d;
`endif

    assign pre_wrap_s  = (pre_q == PRE_MAX);
    assign time_zero_s = (min_q == 7'd0) && (sec_q == 6'd0);
    assign last_sec_s  = (min_q == 7'd0) && (sec_q == 6'd1);

    // Next-state: clear beats start, start beats the set buttons; decrement happens before pause.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        pre_d   = pre_q;
        tick_d  = 1'b0;
`ifdef TIMER_CTRL_ALARM_TIMEOUT_EN
        acnt_d  = acnt_q;
`endif
        if (bus.clear_rise) begin
            state_d = ST_SET;
            min_d   = 7'd0;
            sec_d   = 6'd0;
            pre_d   = '0;
`ifdef TIMER_CTRL_ALARM_TIMEOUT_EN
            acnt_d  = '0;
`endif
        end else begin
            case (state_q)
                ST_SET: begin
                    if (bus.start_rise) begin
                        if (!time_zero_s) begin
                            state_d = ST_RUN;
                            pre_d   = '0;
                        end else begin
                            state_d = ST_SET;
                        end
                    end else begin
                        if (bus.min_rise) begin
                            min_d = (min_q == 7'd99) ? 7'd0 : min_q + 7'd1;
                        end else begin
                            min_d = min_q;
                        end
                        if (bus.sec_rise) begin
                            sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                        end else begin
                            sec_d = sec_q;
                        end
                    end
                end
                ST_RUN: begin
                    if (pre_wrap_s) begin
                        pre_d  = '0;
                        tick_d = 1'b1;
                        if (sec_q != 6'd0) begin
                            sec_d = sec_q - 6'd1;
                        end else begin
                            min_d = min_q - 7'd1;
                            sec_d = 6'd59;
                        end
                        if (last_sec_s) begin
                            state_d = ST_ALARM;
`ifdef TIMER_CTRL_ALARM_TIMEOUT_EN
                            acnt_d  = '0;
`endif
                        end else if (bus.start_rise) begin
                            state_d = ST_PAUSE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (bus.start_rise) begin
                        // prescaler is frozen so the partial second resumes where it left off
                        state_d = ST_PAUSE;
                    end else begin
                        pre_d = pre_q + PW'(1'b1);
                    end
                end
                ST_PAUSE: begin
                    if (bus.start_rise) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_ALARM: begin
                    if (bus.start_rise) begin
                        state_d = ST_SET;
                        pre_d   = '0;
`ifdef TIMER_CTRL_ALARM_TIMEOUT_EN
                        acnt_d  = '0;
`endif
                    end else begin
`ifdef TIMER_CTRL_ALARM_TIMEOUT_EN
                        if (pre_wrap_s) begin
                            pre_d = '0;
                            if (acnt_q == ACNT_MAX) begin
                                state_d = ST_SET;
                                acnt_d  = '0;
                            end else begin
                                acnt_d = acnt_q + ACW'(1'b1);
                            end
                        end else begin
                            pre_d = pre_q + PW'(1'b1);
                        end
`else
                        state_d = ST_ALARM;
`endif
                    end
                end
                default: begin
                    state_d = ST_SET;
                end
            endcase
        end
        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_ALARM);
    end

    // State, time and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_SET;
            min_q     <= 7'd0;
            sec_q     <= 6'd0;
            pre_q     <= '0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
`ifdef TIMER_CTRL_ALARM_TIMEOUT_EN
            acnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
`ifdef TIMER_CTRL_ALARM_TIMEOUT_EN
            acnt_q    <= acnt_d;
`endif
        end
    end

    assign bus.minutes  = min_q;
    assign bus.seconds  = sec_q;
    assign bus.running  = running_q;
    assign bus.alarm    = alarm_q;
    assign bus.sec_tick = tick_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// Randomized + directed bench for timer_ctrl (TICKS_PER_SEC=4, ALARM_SECS=3) against a
// time-in-seconds reference model; honours TIMER_CTRL_ALARM_TIMEOUT_EN like the design.
module tb_timer_ctrl;
    localparam int TPS = 4;
    localparam int AS  = 3;
    localparam int M_SET = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    timer_ctrl_if ifc ();

    timer_ctrl #(.TICKS_PER_SEC(TPS), .ALARM_SECS(AS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // reference model: remaining time kept as plain minutes/seconds, decremented via total seconds
    int m_state, m_min, m_sec, m_pre, m_acnt, m_tick;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        total++;
        if (got !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task model_reset();
        m_state = M_SET; m_min = 0; m_sec = 0; m_pre = 0; m_acnt = 0; m_tick = 0;
    endtask

    task model_step(input bit m, input bit s, input bit st, input bit cl);
        int t;
        m_tick = 0;
        if (cl) begin
            m_state = M_SET; m_min = 0; m_sec = 0; m_pre = 0; m_acnt = 0;
        end else if (m_state == M_SET) begin
            if (st) begin
                if (m_min * 60 + m_sec > 0) begin
                    m_state = M_RUN; m_pre = 0;
                end
            end else begin
                if (m) m_min = (m_min + 1) % 100;
                if (s) m_sec = (m_sec + 1) % 60;
            end
        end else if (m_state == M_RUN) begin
            if (m_pre == TPS - 1) begin
                m_pre  = 0;
                m_tick = 1;
                t      = m_min * 60 + m_sec - 1;
                m_min  = t / 60;
                m_sec  = t % 60;
                if (t == 0) begin
                    m_state = M_ALARM; m_acnt = 0;
                end else if (st) begin
                    m_state = M_PAUSE;
                end
            end else if (st) begin
                m_state = M_PAUSE;
            end else begin
                m_pre++;
            end
        end else if (m_state == M_PAUSE) begin
            if (st) m_state = M_RUN;
        end else begin
            if (st) begin
                m_state = M_SET; m_pre = 0; m_acnt = 0;
            end else begin
`ifdef TIMER_CTRL_ALARM_TIMEOUT_EN
                if (m_pre == TPS - 1) begin
                    m_pre = 0;
                    m_acnt++;
                    if (m_acnt == AS) begin
                        m_state = M_SET; m_acnt = 0;
                    end
                end else begin
                    m_pre++;
                end
`endif
            end
        end
    endtask

    task compare_all();
        chk("minutes",  ifc.minutes,  m_min);
        chk("seconds",  ifc.seconds,  m_sec);
        chk("running",  ifc.running,  (m_state == M_RUN)   ? 1 : 0);
        chk("alarm",    ifc.alarm,    (m_state == M_ALARM) ? 1 : 0);
        chk("sec_tick", ifc.sec_tick, m_tick);
    endtask

    // one clock: drive pulses, advance model at the edge, compare #1 later
    task cycle(input bit m, input bit s, input bit st, input bit cl);
        ifc.min_rise   = m;
        ifc.sec_rise   = s;
        ifc.start_rise = st;
        ifc.clear_rise = cl;
        @(posedge clk);
        model_step(m, s, st, cl);
        #1;
        compare_all();
        ifc.min_rise   = 1'b0;
        ifc.sec_rise   = 1'b0;
        ifc.start_rise = 1'b0;
        ifc.clear_rise = 1'b0;
    endtask

    task idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task wait_tick(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            seen = ifc.sec_tick;
        end
        chk(tag, seen, 1);
    endtask

    int ticks, last_tick, n;
    bit done;

    initial begin
        ifc.min_rise = 1'b0; ifc.sec_rise = 1'b0; ifc.start_rise = 1'b0; ifc.clear_rise = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // set-mode wraparound
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 61; i++)  cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap_min", ifc.minutes, 0);
        chk("wrap_sec", ifc.seconds, 1);

        // full countdown from 01:01
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        ticks = 0; last_tick = 0; n = 0; done = 1'b0;
        while (!done && n < 400) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
            if (ifc.sec_tick) begin
                ticks++;
                chk("tick_gap", n - last_tick, TPS);
                last_tick = n;
            end
            done = ifc.alarm;
        end
        chk("cd_ticks", ticks, 61);
        chk("cd_alarm", ifc.alarm, 1);
        chk("cd_running", ifc.running, 0);
        chk("cd_time", {ifc.minutes, ifc.seconds}, 0);

        // leaving ALARM
`ifdef TIMER_CTRL_ALARM_TIMEOUT_EN
        idle(11);
        chk("alarm_last", ifc.alarm, 1);
        idle(1);
        chk("alarm_auto_clear", ifc.alarm, 0);
`else
        idle(1000);
        chk("alarm_hold", ifc.alarm, 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("alarm_exit", ifc.alarm, 0);
        chk("alarm_exit_run", ifc.running, 0);
`endif

        // pause/resume from 00:05
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        wait_tick("pause_first_tick");
        idle(2);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("paused_run", ifc.running, 0);
        idle(20);
        chk("pause_hold", ifc.seconds, 4);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("resume_early", ifc.sec_tick, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("resume_tick", ifc.sec_tick, 1);
        chk("resume_sec", ifc.seconds, 3);

        // clear beats start; start ignored at 00:00
        idle(2);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("prio_run", ifc.running, 0);
        chk("prio_time", {ifc.minutes, ifc.seconds}, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("start_zero", ifc.running, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);

        // asynchronous reset mid-run at 00:30
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(6);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_running", ifc.running, 0);
        chk("arst_time", {ifc.minutes, ifc.seconds}, 0);
        chk("arst_alarm", ifc.alarm, 0);
        chk("arst_tick", ifc.sec_tick, 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        compare_all();
        idle(10);
        chk("post_reset_idle", ifc.running, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100000000: clk cycles per countdown second (minimum 2).
REQ-002 SHALL have parameter ALARM_SECS, default 30: alarm auto-clear duration in seconds; used only with ALARM_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port min_rise  input  1: one-cycle debounced rise pulse from the minutes button.
REQ-006 SHALL have port sec_rise  input  1: one-cycle debounced rise pulse from the seconds button.
REQ-007 SHALL have port start_rise  input  1: one-cycle debounced rise pulse from the start/pause button.
REQ-008 SHALL have port clear_rise  input  1: one-cycle debounced rise pulse from the clear button.
REQ-009 SHALL have port minutes  output  7: current minutes value, 0-99, registered.
REQ-010 SHALL have port seconds  output  6: current seconds value, 0-59, registered.
REQ-011 SHALL have port running  output  1: high while in RUN, registered.
REQ-012 SHALL have port alarm  output  1: high while in ALARM, registered.
REQ-013 SHALL have port sec_tick  output  1: one-cycle pulse on each countdown decrement, registered.

Function
REQ-014 SHALL implement a four-state FSM: SET, RUN, PAUSE, ALARM.
REQ-015 SHALL apply input priority within one cycle as clear_rise > start_rise > min_rise/sec_rise.
REQ-016 In SET, SHALL add 1 to minutes on min_rise, wrapping 99->0, with no effect on seconds.
REQ-017 In SET, SHALL add 1 to seconds on sec_rise, wrapping 59->0, with no carry into minutes.
REQ-018 In SET, SHALL apply simultaneous min_rise and sec_rise in the same cycle.
REQ-019 In SET, start_rise SHALL enter RUN and zero the prescaler when the time is nonzero; when the time is 00:00 it SHALL be ignored.
REQ-020 In any state, clear_rise SHALL set minutes and seconds to 0, zero the prescaler and enter SET on the next edge.
REQ-021 In RUN, the prescaler SHALL count 0 to TICKS_PER_SEC-1 and wrap.
REQ-022 On each prescaler wrap, SHALL pulse sec_tick for one cycle and decrement the time: seconds-1 if seconds>0, otherwise minutes-1 and seconds=59.
REQ-023 SHALL enter ALARM on the same edge at which a decrement produces 00:00, so the first ALARM cycle shows 00:00.
REQ-024 In RUN, start_rise SHALL enter PAUSE and hold the prescaler value.
REQ-025 In RUN, min_rise and sec_rise SHALL be ignored.
REQ-026 If start_rise and a prescaler wrap coincide, SHALL apply the decrement and then enter PAUSE (or ALARM if 00:00 is reached).
REQ-027 In PAUSE, start_rise SHALL return to RUN with the prescaler resuming from its held value.
REQ-028 In PAUSE, min_rise and sec_rise SHALL be ignored.
REQ-029 In ALARM, alarm SHALL be 1 and start_rise SHALL enter SET with the time at 00:00.
REQ-030 In ALARM, min_rise and sec_rise SHALL be ignored.
REQ-031 Outputs SHALL reflect the state and values one cycle after the causing input pulse, with no combinational input-to-output paths.

Reset
REQ-032 SHALL, while rst is high, force state=SET, minutes=0, seconds=0, prescaler=0, alarm-second counter=0, running=0, alarm=0, sec_tick=0, independent of clk.
REQ-033 SHALL abandon any countdown or alarm when rst asserts mid-operation, with no residual sec_tick pulse.
REQ-034 SHALL ignore input pulses in the first cycle after rst deasserts only if they coincide with the deassertion edge; otherwise they are accepted normally.

Configuration
REQ-035 SHALL use the macro TIMER_CTRL_ALARM_TIMEOUT_EN to control alarm auto-clear.
REQ-036 With TIMER_CTRL_ALARM_TIMEOUT_EN defined, the prescaler SHALL keep running in ALARM, and after ALARM_SECS prescaler wraps the block SHALL auto-enter SET with alarm=0; sec_tick SHALL stay 0 in ALARM.
REQ-037 Without TIMER_CTRL_ALARM_TIMEOUT_EN, ALARM SHALL persist until start_rise, clear_rise or rst, and the alarm-second counter SHALL not exist.

Verification (TICKS_PER_SEC=4, ALARM_SECS=3)
REQ-038 Set wrap: 100 min_rise and 61 sec_rise pulses in SET -> minutes=0, seconds=1.
REQ-039 Countdown: set 01:01, start -> sec_tick every 4 cycles, display 01:00, 00:59 ... 00:00, with alarm=1 on the 61st tick edge and running=0.
REQ-040 Pause/resume: start at 00:05, pause 2 cycles after a tick, wait 20 cycles, resume -> next tick 2 cycles after resume and seconds unchanged during pause.
REQ-041 Priority: clear_rise and start_rise in the same cycle in RUN -> SET, 00:00, running=0; start_rise at 00:00 in SET -> remains SET.
REQ-042 Alarm exit: with the macro, alarm clears 12 cycles after entry; without it, alarm stays 1 for 1000 cycles, then start_rise gives alarm=0 and SET.
REQ-043 Reset: rst asserted mid-RUN at 00:30 and asynchronous to clk -> outputs are 0 immediately; after release, the block idles in SET.
